// File: rtl/wb_pipe_stage_pkg.sv
// Shared encodings for the writeback stage: result-source select and load funct3 codes.
package wb_pipe_stage_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_IMM  = 2'b11
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_pipe_stage_if.sv
// M-stage inputs, pipeline control and W-stage outputs of the writeback stage.
interface wb_pipe_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             stall_w;
   logic             flush_w;
   logic             valid_m;
   logic             reg_write_m;
   logic [4:0]       rd_m;
   logic [1:0]       result_src_m;
   logic [2:0]       funct3_m;
   logic [XLEN-1:0]  alu_result_m;
   logic [XLEN-1:0]  read_data_m;
   logic [XLEN-1:0]  pc_plus4_m;
   logic [XLEN-1:0]  imm_ext_m;
   logic [XLEN-1:0]  result_w;
   logic [4:0]       rd_w;
   logic             reg_write_w;
   logic [CNT_W-1:0] retired_cnt;

   modport master (
      output stall_w, flush_w, valid_m, reg_write_m, rd_m, result_src_m, funct3_m,
             alu_result_m, read_data_m, pc_plus4_m, imm_ext_m,
      input  result_w, rd_w, reg_write_w, retired_cnt
   );

   modport slave (
      input  stall_w, flush_w, valid_m, reg_write_m, rd_m, result_src_m, funct3_m,
             alu_result_m, read_data_m, pc_plus4_m, imm_ext_m,
      output result_w, rd_w, reg_write_w, retired_cnt
   );
endinterface

// File: rtl/wb_pipe_stage_load_formatter.sv
// Combinational load lane extraction and sign/zero extension.
module load_formatter
   import wb_pipe_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] read_data,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = read_data[7:0];
      case (addr_lo)
         2'b00:   byte_sel = read_data[7:0];
         2'b01:   byte_sel = read_data[15:8];
         2'b10:   byte_sel = read_data[23:16];
         2'b11:   byte_sel = read_data[31:24];
         default: byte_sel = read_data[7:0];
      endcase
      // halfwords are naturally aligned; addr_lo[0] is deliberately ignored
      half_sel = addr_lo[1] ? read_data[31:16] : read_data[15:0];
   end

   always_comb begin
      load_data = read_data;
      case (funct3)
         F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
         default: load_data = read_data;
      endcase
   end

endmodule

// File: rtl/wb_pipe_stage.sv
// M->W pipeline register with result select, load formatting and retired-instruction counter.
module wb_pipe_stage
   import wb_pipe_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   wb_pipe_stage_if.slave wb
);

   logic             valid_q,      valid_d;
   logic             reg_write_q,  reg_write_d;
   logic [4:0]       rd_q,         rd_d;
   result_src_e      result_src_q, result_src_d;
   logic [2:0]       funct3_q,     funct3_d;
   logic [XLEN-1:0]  alu_result_q, alu_result_d;
   logic [XLEN-1:0]  read_data_q,  read_data_d;
   logic [XLEN-1:0]  pc_plus4_q,   pc_plus4_d;
   logic [XLEN-1:0]  imm_ext_q,    imm_ext_d;
   logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
   logic             retire;
   logic [XLEN-1:0]  load_data;

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      rd_d         = rd_q;
      result_src_d = result_src_q;
      funct3_d     = funct3_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      pc_plus4_d   = pc_plus4_q;
      imm_ext_d    = imm_ext_q;

      if (wb.flush_w) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         rd_d         = 5'd0;
         result_src_d = RES_ALU;
         funct3_d     = 3'd0;
         alu_result_d = '0;
         read_data_d  = '0;
         pc_plus4_d   = '0;
         imm_ext_d    = '0;
      end else if (!wb.stall_w) begin
         valid_d      = wb.valid_m;
         reg_write_d  = wb.reg_write_m;
         rd_d         = wb.rd_m;
         result_src_d = result_src_e'(wb.result_src_m);
         funct3_d     = wb.funct3_m;
         alu_result_d = wb.alu_result_m;
         read_data_d  = wb.read_data_m;
         pc_plus4_d   = wb.pc_plus4_m;
         imm_ext_d    = wb.imm_ext_m;
      end
   end

   // The entry leaving W retires even when a flush replaces it in the same cycle.
   always_comb begin
      retire        = valid_q && !wb.stall_w;
      retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= 1'b0;
         reg_write_q   <= 1'b0;
         rd_q          <= 5'd0;
         result_src_q  <= RES_ALU;
         funct3_q      <= 3'd0;
         alu_result_q  <= '0;
         read_data_q   <= '0;
         pc_plus4_q    <= '0;
         imm_ext_q     <= '0;
         retired_cnt_q <= '0;
      end else begin
         valid_q       <= valid_d;
         reg_write_q   <= reg_write_d;
         rd_q          <= rd_d;
         result_src_q  <= result_src_d;
         funct3_q      <= funct3_d;
         alu_result_q  <= alu_result_d;
         read_data_q   <= read_data_d;
         pc_plus4_q    <= pc_plus4_d;
         imm_ext_q     <= imm_ext_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   load_formatter #(
      .XLEN (XLEN)
   ) u_load_formatter (
      .read_data (read_data_q),
      .addr_lo   (alu_result_q[1:0]),
      .funct3    (funct3_q),
      .load_data (load_data)
   );

   always_comb begin
      wb.result_w = alu_result_q;
      case (result_src_q)
         RES_ALU:  wb.result_w = alu_result_q;
         RES_LOAD: wb.result_w = load_data;
         RES_PC4:  wb.result_w = pc_plus4_q;
         RES_IMM:  wb.result_w = imm_ext_q;
         default:  wb.result_w = alu_result_q;
      endcase
   end

   assign wb.rd_w        = rd_q;
   assign wb.reg_write_w = valid_q && reg_write_q && (rd_q != 5'd0);
   assign wb.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed vector table, counter-wrap sequence and random stimulus against a behavioural model.
module tb_wb_pipe_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        flush;
      logic        valid;
      logic        regw;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [31:0] e_res;
      logic [4:0]  e_rd;
      logic        e_we;
      logic [3:0]  e_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   vec_t m_e;
   int   m_cnt;

   wb_pipe_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) mif ();

   wb_pipe_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (mif.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t row(logic r, logic st, logic fl, logic va, logic rw, logic [4:0] rd,
                                logic [1:0] src, logic [2:0] f3, logic [31:0] alu, logic [31:0] rdata,
                                logic [31:0] pc4, logic [31:0] imm, logic [31:0] e_res,
                                logic [4:0] e_rd, logic e_we, logic [3:0] e_cnt);
      vec_t v;
      v.rst = r; v.stall = st; v.flush = fl; v.valid = va; v.regw = rw; v.rd = rd;
      v.src = src; v.f3 = f3; v.alu = alu; v.rdata = rdata; v.pc4 = pc4; v.imm = imm;
      v.e_res = e_res; v.e_rd = e_rd; v.e_we = e_we; v.e_cnt = e_cnt;
      return v;
   endfunction

   // Expected writeback value computed arithmetically from the captured entry.
   function automatic logic [31:0] ref_result(vec_t e);
      longint v;
      int     a;
      a = int'(e.alu[1:0]);
      case (e.src)
         2'd0: return e.alu;
         2'd2: return e.pc4;
         2'd3: return e.imm;
         default: begin
            case (e.f3)
               3'b000: begin v = (e.rdata >> (8*a)) & 255;        if (v > 127)   v -= 256;   return 32'(v); end
               3'b001: begin v = (e.rdata >> (16*(a/2))) & 65535; if (v > 32767) v -= 65536; return 32'(v); end
               3'b100: begin v = (e.rdata >> (8*a)) & 255;        return 32'(v); end
               3'b101: begin v = (e.rdata >> (16*(a/2))) & 65535; return 32'(v); end
               default: return e.rdata;
            endcase
         end
      endcase
   endfunction

   task automatic model_edge(input vec_t v);
      vec_t z;
      z = '{default: '0};
      if (v.rst) begin
         m_e   = z;
         m_cnt = 0;
      end else begin
         if (m_e.valid && !v.stall) m_cnt = (m_cnt + 1) % 16;
         if (v.flush)       m_e = z;
         else if (!v.stall) m_e = v;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t v);
      rst              = v.rst;
      mif.stall_w      = v.stall;
      mif.flush_w      = v.flush;
      mif.valid_m      = v.valid;
      mif.reg_write_m  = v.regw;
      mif.rd_m         = v.rd;
      mif.result_src_m = v.src;
      mif.funct3_m     = v.f3;
      mif.alu_result_m = v.alu;
      mif.read_data_m  = v.rdata;
      mif.pc_plus4_m   = v.pc4;
      mif.imm_ext_m    = v.imm;
      @(posedge clk);
      model_edge(v);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_result"}, 64'(mif.result_w), 64'(ref_result(m_e)));
      chk({tag, "_rd"},     64'(mif.rd_w), 64'(m_e.rd));
      chk({tag, "_we"},     64'(mif.reg_write_w), 64'(m_e.valid && m_e.regw && (m_e.rd != 5'd0)));
      chk({tag, "_cnt"},    64'(mif.retired_cnt), 64'(m_cnt));
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      m_e   = '{default: '0};
      m_cnt = 0;
      v     = '{default: '0};
      v.rst = 1'b1;
      rst   = 1'b1;
      step(v);

      //          rst st fl va rw rd     src    f3      alu           rdata         pc4           imm            e_res         e_rd   we e_cnt
      tbl.push_back(row(1, 0, 0, 1, 1, 5'd9,  2'b00, 3'b000, 32'h0000_0777, 32'h0,        32'h0,        32'h0,         32'h0000_0000, 5'd0,  0, 4'd0));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd3,  2'b01, 3'b000, 32'h0000_1000, 32'h8877_66F0, 32'h0,        32'h0,         32'hFFFF_FFF0, 5'd3,  1, 4'd0));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd4,  2'b01, 3'b100, 32'h0000_1000, 32'h8877_66F0, 32'h0,        32'h0,         32'h0000_00F0, 5'd4,  1, 4'd1));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd6,  2'b01, 3'b001, 32'h0000_1002, 32'h8001_1234, 32'h0,        32'h0,         32'hFFFF_8001, 5'd6,  1, 4'd2));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd7,  2'b01, 3'b101, 32'h0000_1003, 32'h8001_1234, 32'h0,        32'h0,         32'h0000_8001, 5'd7,  1, 4'd3));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd5,  2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0104, 32'h0,         32'h0000_0104, 5'd5,  1, 4'd4));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd0,  2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0104, 32'h0,         32'h0000_0104, 5'd0,  0, 4'd5));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd8,  2'b01, 3'b000, 32'h0000_2001, 32'h8877_66F0, 32'h0,        32'h0,         32'h0000_0066, 5'd8,  1, 4'd6));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd8,  2'b01, 3'b000, 32'h0000_2003, 32'h8877_66F0, 32'h0,        32'h0,         32'hFFFF_FF88, 5'd8,  1, 4'd7));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd11, 2'b01, 3'b010, 32'h0000_2001, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'hDEAD_BEEF, 5'd11, 1, 4'd8));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd11, 2'b01, 3'b011, 32'h0000_2002, 32'h1234_5678, 32'h0,        32'h0,         32'h1234_5678, 5'd11, 1, 4'd9));
      tbl.push_back(row(0, 0, 0, 1, 0, 5'd9,  2'b00, 3'b000, 32'hCAFE_F00D, 32'h0,        32'h0,        32'h0,         32'hCAFE_F00D, 5'd9,  0, 4'd10));
      tbl.push_back(row(0, 0, 0, 0, 1, 5'd10, 2'b11, 3'b000, 32'h0,         32'h0,         32'h0,        32'hFFFF_F800, 32'hFFFF_F800, 5'd10, 0, 4'd11));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd1,  2'b00, 3'b000, 32'h0000_0011, 32'h0,        32'h0,        32'h0,         32'h0000_0011, 5'd1,  1, 4'd11));
      tbl.push_back(row(0, 1, 0, 1, 1, 5'd2,  2'b11, 3'b000, 32'h0,         32'h0,         32'h0,        32'h0000_0055, 32'h0000_0011, 5'd1,  1, 4'd11));
      tbl.push_back(row(0, 1, 0, 1, 1, 5'd3,  2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0999, 32'h0,         32'h0000_0011, 5'd1,  1, 4'd11));
      tbl.push_back(row(0, 1, 0, 0, 0, 5'd4,  2'b01, 3'b000, 32'h0,         32'h1111_1111, 32'h0,        32'h0,         32'h0000_0011, 5'd1,  1, 4'd11));
      tbl.push_back(row(0, 1, 1, 1, 1, 5'd4,  2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0888, 32'h0,         32'h0000_0000, 5'd0,  0, 4'd11));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd12, 2'b00, 3'b000, 32'h0000_0022, 32'h0,        32'h0,        32'h0,         32'h0000_0022, 5'd12, 1, 4'd11));
      tbl.push_back(row(0, 0, 1, 1, 1, 5'd15, 2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0444, 32'h0,         32'h0000_0000, 5'd0,  0, 4'd12));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd13, 2'b10, 3'b000, 32'h0,         32'h0,         32'h0000_0200, 32'h0,         32'h0000_0200, 5'd13, 1, 4'd12));
      tbl.push_back(row(1, 0, 0, 1, 1, 5'd14, 2'b00, 3'b000, 32'h0000_0333, 32'h0,        32'h0,        32'h0,         32'h0000_0000, 5'd0,  0, 4'd0));
      tbl.push_back(row(0, 0, 0, 1, 1, 5'd14, 2'b00, 3'b000, 32'h0000_0033, 32'h0,        32'h0,        32'h0,         32'h0000_0033, 5'd14, 1, 4'd0));

      foreach (tbl[i]) begin
         step(tbl[i]);
         chk($sformatf("vec%0d_result", i), 64'(mif.result_w), 64'(tbl[i].e_res));
         chk($sformatf("vec%0d_rd", i),     64'(mif.rd_w), 64'(tbl[i].e_rd));
         chk($sformatf("vec%0d_we", i),     64'(mif.reg_write_w), 64'(tbl[i].e_we));
         chk($sformatf("vec%0d_cnt", i),    64'(mif.retired_cnt), 64'(tbl[i].e_cnt));
      end

      // Counter wrap: reset, then 17 back-to-back valid instructions.
      v = '{default: '0};
      v.rst = 1'b1;
      step(v);
      v.rst = 1'b0; v.valid = 1'b1; v.regw = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         v.rd  = 5'(n);
         v.alu = 32'(n * 16);
         step(v);
         chk($sformatf("wrap%0d_cnt", n), 64'(mif.retired_cnt), 64'((n - 1) % 16));
      end
      chk("wrap_all_ones_then_zero", 64'(mif.retired_cnt), 64'd0);

      // Random stimulus against the behavioural model.
      v = '{default: '0};
      v.rst = 1'b1;
      step(v);
      for (int n = 0; n < 3000; n++) begin
         v.rst   = ($urandom_range(0, 63) == 0);
         v.stall = ($urandom_range(0, 3) == 0);
         v.flush = ($urandom_range(0, 7) == 0);
         v.valid = ($urandom_range(0, 4) != 0);
         v.regw  = 1'($urandom);
         v.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         v.src   = 2'($urandom);
         v.f3    = 3'($urandom);
         v.alu   = $urandom;
         v.rdata = $urandom;
         v.pc4   = $urandom;
         v.imm   = $urandom;
         step(v);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
